// File: rtl/oops_structs.sv
// Shared out-of-order pipeline types: ROB geometry, ROB entry, issue-queue element, regfile bus.
package oops_structs;

   localparam int unsigned ROB_DEPTH = 16;
   localparam int unsigned ROB_TAG_W = $clog2(ROB_DEPTH);
   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned OPCODE_W  = 7;

   typedef logic [ROB_TAG_W-1:0] rob_tag_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // One reorder buffer slot at the default geometry
   typedef struct packed {
      logic            busy;
      logic            done;
      reg_idx_t        dest_reg;
      logic [XLEN-1:0] data;
   } rob_entry_t;

   // Instruction queue element waiting on its operands
   typedef struct packed {
      logic                valid;
      logic [OPCODE_W-1:0] opcode;
      reg_idx_t            rd;
      reg_idx_t            rs1;
      reg_idx_t            rs2;
      rob_tag_t            rob_dest;
      rob_tag_t            rs1_tag;
      logic                rs1_rdy;
      logic [XLEN-1:0]     rs1_val;
      rob_tag_t            rs2_tag;
      logic                rs2_rdy;
      logic [XLEN-1:0]     rs2_val;
   } instruction_element_t;

   // Regfile write bus driven by retirement
   typedef struct packed {
      logic            we;
      reg_idx_t        addr;
      rob_tag_t        tag;
      logic [XLEN-1:0] data;
   } reg_bus_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order writeback, in-order retirement.
module reorder_buffer
   import oops_structs::*;
#(
   parameter  int unsigned DEPTH = ROB_DEPTH,
   parameter  int unsigned WIDTH = XLEN,
   localparam int unsigned TAG_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 alloc_vld_i,
   input  logic [REG_IDX_W-1:0] alloc_dest_reg_i,
   output logic                 alloc_rdy_o,
   output logic [TAG_W-1:0]     rob_dest_o,
   input  logic                 cdb_vld_i,
   input  logic [TAG_W-1:0]     cdb_tag_i,
   input  logic [WIDTH-1:0]     cdb_data_i,
   input  logic [TAG_W-1:0]     rd_tag_i,
   output logic                 rd_ready_o,
   output logic [WIDTH-1:0]     rd_data_o,
   output logic                 commit_vld_o,
   output logic [REG_IDX_W-1:0] commit_reg_o,
   output logic [TAG_W-1:0]     commit_tag_o,
   output logic [WIDTH-1:0]     commit_data_o
);

   logic [DEPTH-1:0]     busy_q, busy_d;
   logic [DEPTH-1:0]     done_q, done_d;
   reg_idx_t             dest_q [DEPTH];
   reg_idx_t             dest_d [DEPTH];
   logic [WIDTH-1:0]     data_q [DEPTH];
   logic [WIDTH-1:0]     data_d [DEPTH];
   logic [TAG_W-1:0]     head_q, head_d;
   logic [TAG_W-1:0]     tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;

   logic                 alloc_fire;
   logic                 retire;
   logic                 wb_fire;

   // Handshake, retirement and operand-read views of the current state
   always_comb begin
      alloc_rdy_o   = (count_q < CNT_W'(DEPTH));
      rob_dest_o    = tail_q;
      alloc_fire    = alloc_vld_i & alloc_rdy_o;
      // A full buffer does not count the same-cycle retirement as free space
      retire        = busy_q[head_q] & done_q[head_q] & ~flush;
      commit_vld_o  = retire & (dest_q[head_q] != '0);
      commit_reg_o  = dest_q[head_q];
      commit_tag_o  = head_q;
      commit_data_o = data_q[head_q];
      // Retiring head is never rewritten on its way out
      wb_fire       = cdb_vld_i & busy_q[cdb_tag_i] &
                      ~(retire & (cdb_tag_i == head_q));
      if (cdb_vld_i && (cdb_tag_i == rd_tag_i)) begin
         rd_ready_o = 1'b1;
         rd_data_o  = cdb_data_i;
      end else begin
         rd_ready_o = done_q[rd_tag_i];
         rd_data_o  = data_q[rd_tag_i];
      end
   end

   // Next-state: flush overrides everything, otherwise writeback, allocate, retire
   always_comb begin
      busy_d  = busy_q;
      done_d  = done_q;
      dest_d  = dest_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (flush) begin
         busy_d  = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (wb_fire) begin
            done_d[cdb_tag_i] = 1'b1;
            data_d[cdb_tag_i] = cdb_data_i;
         end
         if (alloc_fire) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            dest_d[tail_q] = alloc_dest_reg_i;
            data_d[tail_q] = '0;
            tail_d         = tail_q + TAG_W'(1);
         end
         if (retire) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + TAG_W'(1);
         end
         unique case ({alloc_fire, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with asynchronous clear of every entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         done_q  <= '0;
         dest_q  <= '{default: '0};
         data_q  <= '{default: '0};
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         done_q  <= done_d;
         dest_q  <= dest_d;
         data_q  <= data_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized + directed check of reorder_buffer against an in-order queue model.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        alloc_vld_i;
   logic [4:0]  alloc_dest_reg_i;
   logic        alloc_rdy_o;
   logic [3:0]  rob_dest_o;
   logic        cdb_vld_i;
   logic [3:0]  cdb_tag_i;
   logic [31:0] cdb_data_i;
   logic [3:0]  rd_tag_i;
   logic        rd_ready_o;
   logic [31:0] rd_data_o;
   logic        commit_vld_o;
   logic [4:0]  commit_reg_o;
   logic [3:0]  commit_tag_o;
   logic [31:0] commit_data_o;

   reorder_buffer #(.DEPTH(16), .WIDTH(32)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .flush            (flush),
      .alloc_vld_i      (alloc_vld_i),
      .alloc_dest_reg_i (alloc_dest_reg_i),
      .alloc_rdy_o      (alloc_rdy_o),
      .rob_dest_o       (rob_dest_o),
      .cdb_vld_i        (cdb_vld_i),
      .cdb_tag_i        (cdb_tag_i),
      .cdb_data_i       (cdb_data_i),
      .rd_tag_i         (rd_tag_i),
      .rd_ready_o       (rd_ready_o),
      .rd_data_o        (rd_data_o),
      .commit_vld_o     (commit_vld_o),
      .commit_reg_o     (commit_reg_o),
      .commit_tag_o     (commit_tag_o),
      .commit_data_o    (commit_data_o)
   );

   always #5 clk = ~clk;

   // In-flight instructions in program order
   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  dest;
      bit          done;
      logic [31:0] data;
   } ent_t;

   ent_t       q[$];
   logic [3:0] next_tag;
   int         n_chk = 0;
   int         n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      flush            = 1'b0;
      alloc_vld_i      = 1'b0;
      alloc_dest_reg_i = '0;
      cdb_vld_i        = 1'b0;
      cdb_tag_i        = '0;
      cdb_data_i       = '0;
   endtask

   // One clock cycle: drive, check combinational outputs against the model, advance model
   task automatic step(input bit av, input logic [4:0] ad, input bit cv, input logic [3:0] ct,
                       input logic [31:0] cd, input logic [3:0] rt, input bit fl);
      bit exp_cv;
      bit retire;
      alloc_vld_i      = av;
      alloc_dest_reg_i = ad;
      cdb_vld_i        = cv;
      cdb_tag_i        = ct;
      cdb_data_i       = cd;
      rd_tag_i         = rt;
      flush            = fl;
      #1;
      chk("alloc_rdy", 32'(alloc_rdy_o), 32'(q.size() < 16));
      chk("rob_dest", 32'(rob_dest_o), 32'(next_tag));
      exp_cv = !fl && (q.size() > 0) && q[0].done && (q[0].dest != 5'd0);
      chk("commit_vld", 32'(commit_vld_o), 32'(exp_cv));
      if (exp_cv) begin
         chk("commit_reg", 32'(commit_reg_o), 32'(q[0].dest));
         chk("commit_tag", 32'(commit_tag_o), 32'(q[0].tag));
         chk("commit_data", commit_data_o, q[0].data);
      end
      if (cv && (ct == rt)) begin
         chk("rd_fwd_ready", 32'(rd_ready_o), 32'd1);
         chk("rd_fwd_data", rd_data_o, cd);
      end else begin
         foreach (q[i]) begin
            if (q[i].tag == rt) begin
               chk("rd_ready", 32'(rd_ready_o), 32'(q[i].done));
               if (q[i].done) chk("rd_data", rd_data_o, q[i].data);
            end
         end
      end
      @(posedge clk);
      if (fl) begin
         q.delete();
         next_tag = 4'd0;
      end else begin
         retire = (q.size() > 0) && q[0].done;
         if (cv) begin
            foreach (q[i]) begin
               if (q[i].tag == ct && !(retire && i == 0)) begin
                  q[i].done = 1'b1;
                  q[i].data = cd;
               end
            end
         end
         if (av && q.size() < 16) begin
            q.push_back('{tag: next_tag, dest: ad, done: 1'b0, data: 32'd0});
            next_tag = next_tag + 4'd1;
         end
         if (retire) void'(q.pop_front());
      end
      #1;
      idle_inputs();
   endtask

   task automatic do_flush();
      step(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
   endtask

   task automatic do_alloc(input logic [4:0] d);
      step(1'b1, d, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
   endtask

   task automatic do_wb(input logic [3:0] t, input logic [31:0] d);
      step(1'b0, 5'd0, 1'b1, t, d, 4'd0, 1'b0);
   endtask

   task automatic do_idle();
      step(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
   endtask

   initial begin
      bit          av, cv, fl;
      logic [3:0]  ct, rt;
      rst_n    = 1'b0;
      rd_tag_i = '0;
      next_tag = 4'd0;
      idle_inputs();
      #2;
      chk("rst_alloc_rdy", 32'(alloc_rdy_o), 32'd1);
      chk("rst_rob_dest", 32'(rob_dest_o), 32'd0);
      chk("rst_commit_vld", 32'(commit_vld_o), 32'd0);
      chk("rst_rd_ready", 32'(rd_ready_o), 32'd0);
      chk("rst_rd_data", rd_data_o, 32'd0);
      chk("rst_commit_data", commit_data_o, 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single allocate, writeback, commit next cycle
      do_alloc(5'd4);
      do_wb(4'd0, 32'hDEADBEEF);
      #1;
      chk("s1_commit_vld", 32'(commit_vld_o), 32'd1);
      chk("s1_commit_reg", 32'(commit_reg_o), 32'd4);
      chk("s1_commit_tag", 32'(commit_tag_o), 32'd0);
      chk("s1_commit_data", commit_data_o, 32'hDEADBEEF);
      do_idle();

      // Out-of-order writeback, in-order commit on consecutive cycles
      do_flush();
      do_alloc(5'd7);
      do_alloc(5'd9);
      do_wb(4'd1, 32'h11111111);
      do_idle();
      #1 chk("s2_no_early_commit", 32'(commit_vld_o), 32'd0);
      do_wb(4'd0, 32'h22222222);
      #1 chk("s2_first_tag", 32'(commit_tag_o), 32'd0);
      do_idle();
      #1 chk("s2_second_vld", 32'(commit_vld_o), 32'd1);
      chk("s2_second_tag", 32'(commit_tag_o), 32'd1);
      chk("s2_second_data", commit_data_o, 32'h11111111);
      do_idle();

      // Fill to full, no bypass on same-cycle commit, wrap to tag 0
      do_flush();
      for (int i = 0; i < 16; i++) do_alloc(5'(i % 31 + 1));
      #1;
      chk("s3_full_rdy", 32'(alloc_rdy_o), 32'd0);
      chk("s3_full_dest", 32'(rob_dest_o), 32'd0);
      do_wb(4'd0, 32'h00000077);
      #1;
      chk("s3_commit_vld", 32'(commit_vld_o), 32'd1);
      chk("s3_no_bypass", 32'(alloc_rdy_o), 32'd0);
      do_idle();
      #1;
      chk("s3_rdy_after", 32'(alloc_rdy_o), 32'd1);
      chk("s3_next_tag", 32'(rob_dest_o), 32'd0);
      do_alloc(5'd3);
      #1 chk("s3_tail_after", 32'(rob_dest_o), 32'd1);

      // Read port forwarding from the CDB in the same cycle
      rd_tag_i   = 4'd3;
      cdb_vld_i  = 1'b1;
      cdb_tag_i  = 4'd3;
      cdb_data_i = 32'h0000000E;
      #1;
      chk("fwd_ready", 32'(rd_ready_o), 32'd1);
      chk("fwd_data", rd_data_o, 32'h0000000E);
      cdb_vld_i  = 1'b0;

      // Flush while head is ready to commit
      do_flush();
      for (int i = 0; i < 5; i++) do_alloc(5'(i + 1));
      do_wb(4'd0, 32'hCAFE0000);
      #1 chk("s5_would_commit", 32'(commit_vld_o), 32'd1);
      do_flush();
      #1;
      chk("s5_dest_zero", 32'(rob_dest_o), 32'd0);
      chk("s5_rdy", 32'(alloc_rdy_o), 32'd1);
      chk("s5_no_commit", 32'(commit_vld_o), 32'd0);
      do_idle();

      // Asynchronous reset mid-operation
      for (int i = 0; i < 3; i++) do_alloc(5'(i + 10));
      do_wb(4'd0, 32'h0BADF00D);
      #1 chk("s6_pre_commit", 32'(commit_vld_o), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("s6_rst_rdy", 32'(alloc_rdy_o), 32'd1);
      chk("s6_rst_commit", 32'(commit_vld_o), 32'd0);
      chk("s6_rst_dest", 32'(rob_dest_o), 32'd0);
      q.delete();
      next_tag = 4'd0;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 4; i++) do_idle();

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         av = ($urandom_range(2) != 0);
         cv = ($urandom_range(1) != 0);
         fl = ($urandom_range(63) == 0);
         if (q.size() > 0 && $urandom_range(3) != 0)
            ct = q[$urandom_range(q.size() - 1)].tag;
         else
            ct = 4'($urandom);
         if (q.size() > 0 && $urandom_range(3) != 0)
            rt = q[$urandom_range(q.size() - 1)].tag;
         else
            rt = 4'($urandom);
         step(av, 5'($urandom), cv, ct, $urandom, rt, fl);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries; tag width is log2(DEPTH) = 4.
REQ-002 SHALL have parameter WIDTH, default 32, result data width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk  in  1  clock; all state updates on rising edge.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port flush  in  1  synchronous discard of all entries.
REQ-007 Port alloc_vld_i  in  1  dispatch requests one entry.
REQ-008 Port alloc_dest_reg_i  in  5  architectural destination register of the allocating instruction.
REQ-009 Port alloc_rdy_o  out  1  an entry is free.
REQ-010 Port rob_dest_o  out  4  tag the next allocation receives; drives instruction queue rob_dest_i.
REQ-011 Port cdb_vld_i  in  1  result writeback valid.
REQ-012 Port cdb_tag_i  in  4  ROB tag of the result.
REQ-013 Port cdb_data_i  in  WIDTH  result value.
REQ-014 Port rd_tag_i  in  4  operand lookup tag from the instruction queue.
REQ-015 Port rd_ready_o  out  1  the looked-up entry holds a valid result.
REQ-016 Port rd_data_o  out  WIDTH  the looked-up result.
REQ-017 Port commit_vld_o  out  1  head entry retires this cycle.
REQ-018 Port commit_reg_o  out  5  register written by the retiring entry.
REQ-019 Port commit_tag_o  out  4  tag of the retiring entry; the regfile clears CB only if its stored tag matches.
REQ-020 Port commit_data_o  out  WIDTH  value written to the regfile.

Function
REQ-021 SHALL be a circular buffer: head, tail and count (0..DEPTH); each entry holds busy, done, dest_reg and data.
REQ-022 alloc_rdy_o SHALL be (count < DEPTH); rob_dest_o SHALL equal tail, combinationally.
REQ-023 On an edge with alloc_vld_i and alloc_rdy_o high, entry[tail] SHALL be set to busy=1, done=0, dest_reg, data=0, and tail SHALL advance, wrapping 15->0.
REQ-024 When full, alloc_rdy_o SHALL stay 0 even if a commit occurs the same cycle (no bypass).
REQ-025 On an edge with cdb_vld_i high and entry[cdb_tag_i] busy, the entry SHALL store cdb_data_i and set done=1.
REQ-026 A writeback to a non-busy entry SHALL be ignored.
REQ-027 commit_vld_o SHALL be high, combinationally, when entry[head] is busy and done, and dest_reg != 0.
REQ-028 When entry[head] is busy and done, the entry SHALL retire on that edge: busy cleared, head advanced with wrap. An x0 destination SHALL retire silently.
REQ-029 Retirement SHALL be at most one entry per cycle, in allocation order.
REQ-030 Latency: a writeback sampled at edge N SHALL give commit_vld_o high during cycle N+1 and retirement at edge N+1.
REQ-031 A writeback to head and a retirement SHALL never happen in the same edge.
REQ-032 Allocation and retirement in the same edge SHALL leave count unchanged.
REQ-033 rd_ready_o/rd_data_o SHALL reflect entry[rd_tag_i].done/data.
REQ-034 When cdb_vld_i is high and cdb_tag_i == rd_tag_i, the read port SHALL forward cdb_data_i with rd_ready_o=1 in the same cycle.
REQ-035 flush SHALL take priority over allocation, writeback and retirement: all busy cleared, head=tail=count=0.
REQ-036 commit_vld_o SHALL be 0 during a flush cycle.

Reset
REQ-037 While rst_n is low, all entries SHALL be cleared and head=tail=count=0, immediately and regardless of clk.
REQ-038 Output values during reset: alloc_rdy_o=1, rob_dest_o=0, commit_vld_o=0, rd_ready_o=0, rd_data_o=0, commit_data_o=0.
REQ-039 Reset asserted mid-operation SHALL discard all in-flight entries, with no commit.

Structure
REQ-040 rob_entry_t, rob_tag_t and ROB_DEPTH SHALL live in package oops_structs, alongside instruction_element_t and reg_bus_t.
REQ-041 The block SHALL be a single module with no sub-module; pointer wrap SHALL use natural 4-bit overflow.

Verification
REQ-042 Allocate dest x4 (tag 0), then writeback tag 0 data 32'hDEADBEEF -> next cycle commit_vld_o=1, commit_reg_o=4, commit_tag_o=0, commit_data_o=32'hDEADBEEF.
REQ-043 Allocate tags 0,1; writeback tag 1 first, then tag 0 two cycles later -> commits in order 0 then 1, on consecutive cycles.
REQ-044 16 allocations without writeback -> alloc_rdy_o=0 and rob_dest_o=0. Then writeback tag 0 -> one retire, alloc_rdy_o=1 next cycle; the next allocation receives tag 0.
REQ-045 rd_tag_i=3 with cdb_vld_i=1, cdb_tag_i=3, cdb_data_i=32'h0000000E in the same cycle -> rd_ready_o=1, rd_data_o=32'h0000000E, combinationally.
REQ-046 Flush with 5 busy entries, one of them done at head -> commit_vld_o=0 that cycle; then count=0, rob_dest_o=0.
REQ-047 rst_n asserted low between clock edges with 3 entries busy -> alloc_rdy_o=1 and commit_vld_o=0 immediately; no commit after release.
